// File: rtl/mem_rd_arbiter_if.sv
// Read-port bundle between the memory read arbiter, its readers and memory port B.
interface mem_rd_arbiter_if #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 64
);
  logic                          stream_rd_en;
  logic [ADDR_WIDTH-1:0]         stream_rd_addr;
  logic                          stream_valid;
  logic [N_REQ-1:0]              req;
  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr;
  logic [N_REQ-1:0]              valid;
  logic                          mem_rd_en;
  logic [ADDR_WIDTH-1:0]         mem_rd_addr;
  logic [DATA_WIDTH-1:0]         mem_dout;
  logic [DATA_WIDTH-1:0]         dout;
  logic                          err;

  // Arbiter side.
  modport slave (
    input  stream_rd_en, stream_rd_addr, req, req_addr, mem_dout,
    output stream_valid, valid, mem_rd_en, mem_rd_addr, dout, err
  );

  // Readers and memory side.
  modport master (
    output stream_rd_en, stream_rd_addr, req, req_addr, mem_dout,
    input  stream_valid, valid, mem_rd_en, mem_rd_addr, dout, err
  );
endinterface

// File: rtl/mem_rd_arbiter.sv
// Memory read-port arbiter: always-granted stream plus N_REQ round-robin single-word readers.
// Optional protocol checker enabled by defining MEM_RD_ARB_CHECK_EN.
module mem_rd_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned RD_LATENCY = 1
) (
  input logic              CLK,
  input logic              RST,
  mem_rd_arbiter_if.slave  bus
);
  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      nxt_ptr;
  logic [N_REQ-1:0]      inflight;
  logic [N_REQ-1:0]      elig;
  logic [N_REQ-1:0]      grant;
  logic                  found;
  logic [RD_LATENCY-1:0] tag_stream;
  logic [N_REQ-1:0]      tag_req [RD_LATENCY];

  assign elig = bus.req & ~inflight;

  // Round-robin as two passes: first eligible at/after rr_ptr, else first eligible overall.
  always_comb begin
    grant           = '0;
    found           = 1'b0;
    nxt_ptr         = rr_ptr;
    bus.mem_rd_addr = bus.stream_rd_addr;
    if (!bus.stream_rd_en) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!found && elig[i] && (i >= 32'(rr_ptr))) begin
          found           = 1'b1;
          grant[i]        = 1'b1;
          nxt_ptr         = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
          bus.mem_rd_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
      end
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!found && elig[i]) begin
          found           = 1'b1;
          grant[i]        = 1'b1;
          nxt_ptr         = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
          bus.mem_rd_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
      end
    end
  end

  assign bus.mem_rd_en = bus.stream_rd_en | (|grant);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_ptr     <= '0;
      inflight   <= '0;
      tag_stream <= '0;
      for (int unsigned s = 0; s < RD_LATENCY; s++) tag_req[s] <= '0;
    end else begin
      rr_ptr        <= nxt_ptr;
      inflight      <= (inflight & ~bus.valid) | grant;
      tag_stream[0] <= bus.stream_rd_en;
      tag_req[0]    <= grant;
      for (int unsigned s = 1; s < RD_LATENCY; s++) begin
        tag_stream[s] <= tag_stream[s-1];
        tag_req[s]    <= tag_req[s-1];
      end
    end
  end

  assign bus.stream_valid = tag_stream[RD_LATENCY-1];
  assign bus.valid        = tag_req[RD_LATENCY-1];
  assign bus.dout         = DATA_WIDTH'(bus.mem_dout);

`ifdef MEM_RD_ARB_CHECK_EN
  logic                        err_q;
  logic [N_REQ*ADDR_WIDTH-1:0] addr_q;
  logic [N_REQ-1:0]            drop_viol;
  logic [N_REQ-1:0]            addr_viol;

  // Only reads still waiting for their valid are protected.
  always_comb begin
    drop_viol = '0;
    addr_viol = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      drop_viol[i] = inflight[i] & ~bus.valid[i] & ~bus.req[i];
      addr_viol[i] = inflight[i] & ~bus.valid[i] &
                     (bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] != addr_q[i*ADDR_WIDTH +: ADDR_WIDTH]);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      addr_q <= bus.req_addr;
      if (|(drop_viol | addr_viol)) begin
        err_q <= 1'b1;
`ifndef SYNTHESIS
        $display("mem_rd_arbiter: protocol violation drop=%b addr_change=%b", drop_viol, addr_viol);
`endif
      end
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed self-checking bench for mem_rd_arbiter (N_REQ=4, RD_LATENCY=2).
module tb_mem_rd_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned AW = 9;
  localparam int unsigned DW = 64;
  localparam int unsigned LAT = 2;
`ifdef MEM_RD_ARB_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   fails = 0;
  int   sv_count = 0;

  always #5 clk = ~clk;

  mem_rd_arbiter_if #(.N_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_rd_arbiter #(
    .N_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  function automatic logic [63:0] mw(logic [8:0] a);
    return 64'hA5A5_0000_0000_0000 | {55'd0, a};
  endfunction

  // Memory model: data for the address presented at cycle t appears at t+LAT.
  logic [8:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= bus.mem_rd_addr;
    mpipe[1] <= mpipe[0];
  end
  assign bus.mem_dout = mw(mpipe[LAT-1]);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int unsigned i, input logic [8:0] a);
    bus.req_addr[i*AW +: AW] = a;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] rr_addr [5];
    logic [3:0] rr_valid [5];
    rr_addr  = '{9'h100, 9'h101, 9'h102, 9'h103, 9'h100};
    rr_valid = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100};

    bus.stream_rd_en   = 1'b0;
    bus.stream_rd_addr = '0;
    bus.req            = '0;
    bus.req_addr       = '0;

    // Reset state
    tick();
    #1;
    chk("rst_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
    chk("rst_valid", 64'(bus.valid), 64'd0);
    chk("rst_stream_valid", 64'(bus.stream_valid), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_rr_ptr", 64'(dut.rr_ptr), 64'd0);
    rst = 1'b0;

    // Single request and earliest reissue
    bus.req = 4'b0001;
    set_addr(0, 9'h012);
    #1;
    chk("t1_en", 64'(bus.mem_rd_en), 64'd1);
    chk("t1_addr", 64'(bus.mem_rd_addr), 64'h012);
    tick();
    #1;
    chk("t1_no_reissue_inflight", 64'(bus.mem_rd_en), 64'd0);
    chk("t1_inflight", 64'(dut.inflight), 64'b0001);
    chk("t1_valid_early", 64'(bus.valid), 64'd0);
    tick();
    chk("t1_valid", 64'(bus.valid), 64'b0001);
    chk("t1_dout", bus.dout, mw(9'h012));
    set_addr(0, 9'h034);
    #1;
    chk("t1_no_reissue_at_valid", 64'(bus.mem_rd_en), 64'd0);
    tick();
    #1;
    chk("t1_reissue_en", 64'(bus.mem_rd_en), 64'd1);
    chk("t1_reissue_addr", 64'(bus.mem_rd_addr), 64'h034);
    tick();
    tick();
    #1;
    chk("t1_valid2", 64'(bus.valid), 64'b0001);
    chk("t1_dout2", bus.dout, mw(9'h034));
    bus.req = '0;
    tick();

    // Round-robin across all four requesters
    reset_dut();
    for (int unsigned i = 0; i < NR; i++) set_addr(i, 9'(32'h100 + i));
    bus.req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("rr_addr_c%0d", c), 64'(bus.mem_rd_addr), 64'(rr_addr[c]));
      chk($sformatf("rr_en_c%0d", c), 64'(bus.mem_rd_en), 64'd1);
      chk($sformatf("rr_valid_c%0d", c), 64'(bus.valid), 64'(rr_valid[c]));
      tick();
    end
    bus.req = 4'b0001;
    #1;
    chk("rr_valid_c5", 64'(bus.valid), 64'b1000);
    chk("rr_en_c5", 64'(bus.mem_rd_en), 64'd0);
    tick();
    #1;
    chk("rr_valid_c6", 64'(bus.valid), 64'b0001);
    chk("rr_dout_c6", bus.dout, mw(9'h100));
    chk("rr_ptr_after", 64'(dut.rr_ptr), 64'd1);
    bus.req = '0;
    tick();

    // Stream priority: five stream cycles with requester 2 waiting
    bus.req = 4'b0100;
    set_addr(2, 9'h0A2);
    for (int k = 0; k < 5; k++) begin
      bus.stream_rd_en   = 1'b1;
      bus.stream_rd_addr = 9'(32'h1F0 + k);
      #1;
      chk($sformatf("st_en_s%0d", k), 64'(bus.mem_rd_en), 64'd1);
      chk($sformatf("st_addr_s%0d", k), 64'(bus.mem_rd_addr), 64'(32'h1F0 + k));
      chk($sformatf("st_ptr_s%0d", k), 64'(dut.rr_ptr), 64'd1);
      chk($sformatf("st_valid_s%0d", k), 64'(bus.valid), 64'd0);
      if (bus.stream_valid) sv_count++;
      if (k == 2) chk("st_dout_s2", bus.dout, mw(9'h1F0));
      tick();
    end
    bus.stream_rd_en = 1'b0;
    #1;
    chk("st_grant_addr_s5", 64'(bus.mem_rd_addr), 64'h0A2);
    chk("st_grant_en_s5", 64'(bus.mem_rd_en), 64'd1);
    if (bus.stream_valid) sv_count++;
    tick();
    #1;
    chk("st_valid_s6", 64'(bus.valid), 64'd0);
    if (bus.stream_valid) sv_count++;
    tick();
    #1;
    chk("st_sv_s7", 64'(bus.stream_valid), 64'd0);
    chk("st_valid2_s7", 64'(bus.valid), 64'b0100);
    chk("st_dout_s7", bus.dout, mw(9'h0A2));
    chk("st_sv_count", 64'(sv_count), 64'd5);
    bus.req = '0;
    tick();

    // Wrap-around from rr_ptr=3
    bus.req = 4'b1001;
    set_addr(3, 9'h0C3);
    set_addr(0, 9'h0C0);
    #1;
    chk("wr_ptr_w0", 64'(dut.rr_ptr), 64'd3);
    chk("wr_addr_w0", 64'(bus.mem_rd_addr), 64'h0C3);
    tick();
    #1;
    chk("wr_ptr_w1", 64'(dut.rr_ptr), 64'd0);
    chk("wr_addr_w1", 64'(bus.mem_rd_addr), 64'h0C0);
    chk("wr_en_w1", 64'(bus.mem_rd_en), 64'd1);
    tick();
    #1;
    chk("wr_valid_w2", 64'(bus.valid), 64'b1000);
    chk("wr_en_w2", 64'(bus.mem_rd_en), 64'd0);
    tick();
    bus.req = '0;
    #1;
    chk("wr_valid_w3", 64'(bus.valid), 64'b0001);
    chk("wr_ptr_w3", 64'(dut.rr_ptr), 64'd1);
    chk("wr_err", 64'(bus.err), 64'd0);
    tick();

    // Reset one cycle after a grant
    bus.req = 4'b0010;
    set_addr(1, 9'h055);
    #1;
    chk("rm_addr_r0", 64'(bus.mem_rd_addr), 64'h055);
    tick();
    rst = 1'b1;
    bus.req = '0;
    #1;
    chk("rm_valid_in_rst", 64'(bus.valid), 64'd0);
    chk("rm_inflight", 64'(dut.inflight), 64'd0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("rm_no_valid_%0d", c), 64'(bus.valid), 64'd0);
      chk($sformatf("rm_no_sv_%0d", c), 64'(bus.stream_valid), 64'd0);
      tick();
    end
    bus.req = 4'b0010;
    set_addr(1, 9'h066);
    #1;
    chk("rm_new_en", 64'(bus.mem_rd_en), 64'd1);
    chk("rm_new_addr", 64'(bus.mem_rd_addr), 64'h066);
    tick();
    tick();
    #1;
    chk("rm_new_valid", 64'(bus.valid), 64'b0010);
    chk("rm_new_dout", bus.dout, mw(9'h066));
    bus.req = '0;
    tick();

    // Protocol checker: req[1] dropped before its valid
    bus.req = 4'b0010;
    set_addr(1, 9'h077);
    #1;
    chk("ck_en", 64'(bus.mem_rd_en), 64'd1);
    tick();
    bus.req = '0;
    #1;
    chk("ck_err_before", 64'(bus.err), 64'd0);
    tick();
    #1;
    chk("ck_err_set", 64'(bus.err), 64'(ERR_EXP));
    tick();
    tick();
    #1;
    chk("ck_err_held", 64'(bus.err), 64'(ERR_EXP));
    rst = 1'b1;
    #1;
    chk("ck_err_cleared", 64'(bus.err), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/mem_rd_arbiter.md
# mem_rd_arbiter

Parametrised read-port arbiter for the engine's main memory 64-bit read port. It extends the two-way process_bytes/CPU read mux to one always-granted streaming requester plus N_REQ single-word requesters. Pending requests are served round-robin, and reads are tracked through a configurable memory read latency. The block sits between the main memory port B and its readers (process_bytes stream, CPU, future readers).

## Interface
- N_REQ, 4: number of single-word requesters (2..8)
- ADDR_WIDTH, 9: memory read address width
- DATA_WIDTH, 64: memory read data width
- RD_LATENCY, 1: cycles from mem_rd_en to valid mem_dout (1..3)

Ports:
- CLK  in  1  clock; one clock; everything is synchronous to it.
- RST  in  1  reset; asynchronous, active-high.
- stream_rd_en  in  1  streaming read this cycle; always granted, no handshake.
- stream_rd_addr  in  ADDR_WIDTH  streaming read address.
- stream_valid  out  1  mem_dout holds the streaming word.
- req  in  N_REQ  level request per requester; held until its valid.
- req_addr  in  N_REQ*ADDR_WIDTH  address per requester; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- valid  out  N_REQ  one-cycle pulse when mem_dout holds requester i's word.
- mem_rd_en  out  1  memory read enable.
- mem_rd_addr  out  ADDR_WIDTH  memory read address.
- mem_dout  in  DATA_WIDTH  memory read data.
- dout  out  DATA_WIDTH  equals mem_dout; shared by all readers.
- err  out  1  sticky protocol error (see Configuration).

## Operation
- **Eligibility:** requester i is eligible when req[i]=1 and inflight[i]=0.
- **Grant:** combinational. If stream_rd_en=1, no requester is granted and mem_rd_addr=stream_rd_addr. Otherwise the first eligible requester at or after rr_ptr (modulo N_REQ) is granted, and mem_rd_addr=req_addr[g].
- **mem_rd_en:** stream_rd_en OR any grant.
- **On a grant g:** inflight[g] is set and rr_ptr is set to (g+1) mod N_REQ. With no grant, rr_ptr holds.
- **Tag pipeline:** RD_LATENCY stages. Each stage carries {stream bit, requester one-hot}. The last stage drives stream_valid and valid.
- **Clearing inflight:** inflight[i] clears the cycle after valid[i]. A requester therefore has at most one read outstanding.
- **Requester protocol:**
  - On seeing valid[i], the requester may drop req[i], or change req_addr and keep req[i] high for the next read.
  - The earliest reissue is the cycle after valid.
  - req_addr must stay stable from req assertion until valid.
- **Stream priority:** the stream has absolute priority. A continuous stream starves the requesters; this is intended, because process_bytes bursts are bounded.

## Timing
- **Reset values:**
  - Outputs: mem_rd_en=0, valid=0, stream_valid=0, err=0.
  - Internal: rr_ptr=0, inflight=0, all tag stages cleared.
  - mem_rd_addr and mem_rd_en follow the inputs combinationally once RST deasserts.
- **Latency:** a grant at cycle t produces valid[g] (or stream_valid) at t+RD_LATENCY.
- **Throughput:** the stream gets 1 word/cycle. One requester gets 1 word per RD_LATENCY+1 cycles. Several requesters together get up to 1 word/cycle aggregate.
- **Simultaneous events:**
  - Stream and requesters on the same cycle: the stream wins and the requesters wait, unchanged.
  - valid[i] and a new req[i] on the same cycle: no reissue until the next cycle.
- **Wrap-around:** rr_ptr = N_REQ-1 with a grant to N_REQ-1 gives rr_ptr=0.
- **Reset mid-operation:** in-flight reads are discarded. No valid or stream_valid pulse occurs after RST, even though the memory returns data.
- **Outputs:** valid and stream_valid are registered; mem_rd_en and mem_rd_addr are combinational.

## Configuration
- MEM_RD_ARB_CHECK_EN defined:
  - err sets and stays set until RST when either protocol violation occurs: req[i] drops while inflight[i]=1 and valid[i]=0, or req_addr[i] changes while inflight[i]=1 and valid[i]=0.
  - In simulation, each violation also prints a $display message.
- MEM_RD_ARB_CHECK_EN undefined: err is tied to 0 and no checking logic is built.

## Test plan
- **Single request:** RD_LATENCY=1, req=4'b0001, addr0=0x012. Required: mem_rd_en=1 with addr 0x012 at t, valid=4'b0001 at t+1, and no reissue at t+1 even with req held. A reissue with a new addr occurs at t+2.
- **Round-robin:** req=4'b1111 held, addresses distinct, RD_LATENCY=2. Required: grants in order 0,1,2,3,0, and each valid arrives 2 cycles after its grant.
- **Stream priority:** stream_rd_en=1 for 5 cycles with req=4'b0100. Required: 5 stream_valid pulses, valid[2] only 1+RD_LATENCY cycles after the stream ends, and rr_ptr unchanged during the stream.
- **Wrap-around:** rr_ptr=3, req=4'b1001. Required: grant 3, then grant 0.
- **Reset mid-flight:** RST pulse one cycle after a grant with RD_LATENCY=3. Required: no valid pulse, inflight=0, and a new request served normally afterwards.
- **Checker:** MEM_RD_ARB_CHECK_EN defined; req[1] drops before valid[1]. Required: err=1 and held until RST. With the macro undefined, err stays 0 for the same stimulus.
